// File: rtl/tdm_mux_demux_n_pkg.sv
// Shared mode constants and sizing helper for the TDM mux/demux link.
package tdm_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_SKIP  = 1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_mux_demux_n_rr_slot_counter.sv
// Slot pointer and grant generation: fixed rotation or idle-skipping round-robin.
module rr_slot_counter
    import tdm_pkg::*;
#(
    parameter int ID        = 1,
    parameter int CHANNELS  = 4,
    parameter int SKIP_IDLE = 1,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_valid,
    output logic [SELW-1:0]     grant,
    output logic                grant_vld,
    output logic [CHANNELS-1:0] in_ready,
    output logic [SELW-1:0]     slot
);

    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;
    logic [SELW-1:0] grant_c;
    logic            found;

    // The instance tag carries no function.
    logic unused_id;
    assign unused_id = (ID < 0);

    if (SKIP_IDLE == MODE_SKIP) begin : g_skip
        logic [CHANNELS-1:0] rot;
        int                  off;
        int                  idx;

        // Rotate so bit 0 is the channel at ptr; lowest set bit is the winner.
        always_comb begin
            rot = CHANNELS'({in_valid, in_valid} >> ptr);
            off = 0;
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                if (rot[k]) off = k;
            end
            idx = int'(ptr) + off;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            found   = |in_valid;
            grant_c = SELW'(idx);
        end
    end else begin : g_fixed
        logic unused_vld;
        assign unused_vld = ^in_valid;
        assign found      = 1'b1;
        assign grant_c    = ptr;
    end

    always_comb begin
        ptr_nxt = ptr;
        if (found) ptr_nxt = (grant_c == LAST) ? '0 : grant_c + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr <= '0;
        else      ptr <= ptr_nxt;
    end

    assign grant     = grant_c;
    assign grant_vld = rst & found;
    assign in_ready  = grant_vld ? (CHANNELS'(1) << grant_c) : '0;
    assign slot      = ptr;

endmodule

// File: rtl/tdm_mux_demux_n.sv
// N-channel TDM link: slot-granted mux, non-stalling tagged lane, demux with held outputs.
module tdm_mux_demux_n
    import tdm_pkg::*;
#(
    parameter int ID        = 1,
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int STAGES    = 1,
    parameter int SKIP_IDLE = 1,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0][WIDTH-1:0]  in_data,
    input  logic [CHANNELS-1:0]             in_valid,
    output logic [CHANNELS-1:0]             in_ready,
    output logic [CHANNELS-1:0][WIDTH-1:0]  out_data,
    output logic [CHANNELS-1:0]             out_valid,
    output logic [SELW-1:0]                 slot,
    output logic                            busy
);

    typedef struct packed {
        logic             vld;
        logic [SELW-1:0]  ch;
        logic [WIDTH-1:0] data;
    } lane_t;

    logic [SELW-1:0]               grant;
    logic                          grant_vld;
    lane_t                         lane_in;
    lane_t [STAGES-1:0]            lane_p;
    lane_t                         last;
    logic [CHANNELS-1:0][WIDTH-1:0] hold;

    rr_slot_counter #(
        .ID        (ID),
        .CHANNELS  (CHANNELS),
        .SKIP_IDLE (SKIP_IDLE)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .grant     (grant),
        .grant_vld (grant_vld),
        .in_ready  (in_ready),
        .slot      (slot)
    );

    // Mux: in_ready is one-hot, so an AND-OR select picks the granted word.
    always_comb begin
        lane_in      = '0;
        lane_in.vld  = grant_vld & (|(in_valid & in_ready));
        lane_in.ch   = grant;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ready[i]) lane_in.data = in_data[i];
        end
    end

    // Lane stages p0..p(STAGES-1); never stalls, bubbles travel as vld=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_p <= '0;
        end else begin
            lane_p[0] <= lane_in;
            for (int s = 1; s < STAGES; s++) lane_p[s] <= lane_p[s-1];
        end
    end

    assign last = lane_p[STAGES-1];

    // Demux: the last stage is shown directly in its delivery cycle, then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (last.vld && (last.ch == SELW'(i))) hold[i] <= last.data;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = hold;
        for (int i = 0; i < CHANNELS; i++) begin
            out_valid[i] = last.vld && (last.ch == SELW'(i));
            if (out_valid[i]) out_data[i] = last.data;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) busy = busy | lane_p[s].vld;
    end

endmodule

// File: tb/tb_tdm_mux_demux_n.sv
// Scoreboard bench for tdm_mux_demux_n: fixed-slot, skip-idle and deep-lane instances.
module tb_tdm_mux_demux_n;

    typedef struct packed {
        int          due;
        int          ch;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: fixed slots, 4 channels, 1 stage
    logic [3:0][15:0] a_in_data, a_out_data;
    logic [3:0]       a_in_valid, a_in_ready, a_out_valid;
    logic [1:0]       a_slot;
    logic             a_busy;
    // B: skip idle, 3 channels, 1 stage
    logic [2:0][15:0] b_in_data, b_out_data;
    logic [2:0]       b_in_valid, b_in_ready, b_out_valid;
    logic [1:0]       b_slot;
    logic             b_busy;
    // C: skip idle, 5 channels, 3 stages
    logic [4:0][15:0] c_in_data, c_out_data;
    logic [4:0]       c_in_valid, c_in_ready, c_out_valid;
    logic [2:0]       c_slot;
    logic             c_busy;

    tdm_mux_demux_n #(.ID(1), .WIDTH(16), .CHANNELS(4), .STAGES(1), .SKIP_IDLE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .slot(a_slot), .busy(a_busy));

    tdm_mux_demux_n #(.ID(2), .WIDTH(16), .CHANNELS(3), .STAGES(1), .SKIP_IDLE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .slot(b_slot), .busy(b_busy));

    tdm_mux_demux_n #(.ID(3), .WIDTH(16), .CHANNELS(5), .STAGES(3), .SKIP_IDLE(1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .slot(c_slot), .busy(c_busy));

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitors: pop one expectation per delivered word and check its cycle, tag and data.
    always @(negedge clk) begin
        if (a_out_valid != '0) begin
            if (qa.size() == 0) chk("a_unexpected_out_valid", a_out_valid, 0);
            else begin
                ea = qa.pop_front();
                chk("a_deliver_cycle", cyc, ea.due);
                chk("a_out_valid", a_out_valid, 1 << ea.ch);
                chk("a_out_data", a_out_data[ea.ch], ea.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid != '0) begin
            if (qb.size() == 0) chk("b_unexpected_out_valid", b_out_valid, 0);
            else begin
                eb = qb.pop_front();
                chk("b_deliver_cycle", cyc, eb.due);
                chk("b_out_valid", b_out_valid, 1 << eb.ch);
                chk("b_out_data", b_out_data[eb.ch], eb.data);
            end
        end
    end

    always @(negedge clk) begin
        if (c_out_valid != '0) begin
            if (qc.size() == 0) chk("c_unexpected_out_valid", c_out_valid, 0);
            else begin
                ec = qc.pop_front();
                chk("c_deliver_cycle", cyc, ec.due);
                chk("c_out_valid", c_out_valid, 1 << ec.ch);
                chk("c_out_data", c_out_data[ec.ch], ec.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One C cycle: drive valid, then check slot/grant and optionally expect a delivery.
    task automatic c_step(input logic [4:0] v, input int exp_slot, input logic [4:0] exp_rdy,
                          input bit push, input int ch);
        tick();
        c_in_valid = v;
        #3;
        chk("c_slot", c_slot, exp_slot);
        chk("c_in_ready", c_in_ready, exp_rdy);
        if (push) qc.push_back('{cyc + 3, ch, 16'h00C0 + 16'(ch)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_valid = '0; b_in_valid = '0; c_in_valid = '0;
        a_in_data = '0;  b_in_data = '0;  c_in_data = '0;

        // 1. Reset held with random inputs
        for (int r = 0; r < 3; r++) begin
            tick();
            a_in_valid = 4'($urandom); b_in_valid = 3'($urandom); c_in_valid = 5'($urandom);
            a_in_data  = {$urandom(), $urandom()};
            b_in_data  = 48'({$urandom(), $urandom()});
            c_in_data  = 80'({$urandom(), $urandom(), $urandom()});
            #3;
            chk("rst_a_in_ready", a_in_ready, 0);  chk("rst_b_in_ready", b_in_ready, 0);
            chk("rst_c_in_ready", c_in_ready, 0);  chk("rst_a_out_valid", a_out_valid, 0);
            chk("rst_b_out_valid", b_out_valid, 0); chk("rst_c_out_valid", c_out_valid, 0);
            chk("rst_a_out_data", a_out_data, 0);  chk("rst_c_out_data", c_out_data, 0);
            chk("rst_a_slot", a_slot, 0);          chk("rst_c_slot", c_slot, 0);
            chk("rst_a_busy", a_busy, 0);          chk("rst_c_busy", c_busy, 0);
        end

        // 2. Fixed slots, all valid, starting in the release cycle
        tick();
        rst = 1'b1;
        a_in_valid = 4'hF; b_in_valid = '0; c_in_valid = '0;
        for (int i = 0; i < 4; i++) a_in_data[i] = 16'h00A0 + 16'(i);
        for (int i = 0; i < 3; i++) b_in_data[i] = 16'hFFFF;
        b_in_data[2] = 16'h0042;
        for (int i = 0; i < 5; i++) c_in_data[i] = 16'h00C0 + 16'(i);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) tick();
            #3;
            chk("a_slot", a_slot, j % 4);
            chk("a_in_ready", a_in_ready, 1 << (j % 4));
            qa.push_back('{cyc + 1, j % 4, 16'h00A0 + 16'(j % 4)});
        end

        // 3. Skip idle, only ch2 valid: granted every cycle, pointer wraps back to 0
        tick();
        a_in_valid = '0;
        b_in_valid = 3'b100;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            #3;
            chk("b_slot", b_slot, 0);
            chk("b_in_ready", b_in_ready, 3'b100);
            qb.push_back('{cyc + 1, 2, 16'h0042});
        end
        tick();
        b_in_valid = '0;
        #3;
        chk("b_in_ready_idle", b_in_ready, 0);
        for (int i = 0; i < 4; i++) chk("a_held_out_data", a_out_data[i], 16'h00A0 + i);
        chk("b_held_ch2", b_out_data[2], 16'h0042);
        chk("b_untouched_ch0", b_out_data[0], 0);

        // 4. Round-robin fairness, idle ch4 skipped, then ch1 dropped
        c_step(5'b01111, 0, 5'b00001, 1, 0);
        c_step(5'b01111, 1, 5'b00010, 1, 1);
        c_step(5'b01111, 2, 5'b00100, 1, 2);
        c_step(5'b01111, 3, 5'b01000, 1, 3);
        c_step(5'b01111, 4, 5'b00001, 1, 0);
        c_step(5'b01101, 1, 5'b00100, 1, 2);
        c_step(5'b01101, 3, 5'b01000, 1, 3);
        c_step(5'b01101, 4, 5'b00001, 1, 0);
        c_step(5'b01101, 1, 5'b00100, 1, 2);
        for (int j = 0; j < 4; j++) c_step(5'b00000, 3, 5'b00000, 0, 0);
        chk("c_busy_drained", c_busy, 0);

        // 5. Single word through a 3-stage lane: busy for exactly 3 cycles
        c_step(5'b00010, 3, 5'b00010, 1, 1);
        chk("c_busy_before", c_busy, 0);
        for (int j = 1; j <= 4; j++) begin
            c_step(5'b00000, 2, 5'b00000, 0, 0);
            chk("c_busy_window", c_busy, (j <= 3) ? 1 : 0);
        end

        // 6. Wrap 4->0, then reset with two words in flight
        c_step(5'b10000, 2, 5'b10000, 0, 0);
        c_step(5'b00001, 0, 5'b00001, 0, 0);
        tick();
        c_in_valid = '0;
        rst = 1'b0;
        #3;
        for (int j = 0; j < 2; j++) begin
            if (j > 0) begin tick(); #3; end
            chk("c_rst_busy", c_busy, 0);
            chk("c_rst_in_ready", c_in_ready, 0);
            chk("c_rst_out_valid", c_out_valid, 0);
            chk("c_rst_slot", c_slot, 0);
            chk("c_rst_out_data", c_out_data, 0);
        end
        tick();
        rst = 1'b1;
        c_in_valid = 5'b01100;
        #3;
        chk("c_post_rst_slot", c_slot, 0);
        chk("c_post_rst_in_ready", c_in_ready, 5'b00100);
        qc.push_back('{cyc + 3, 2, 16'h00C2});
        for (int j = 0; j < 6; j++) begin
            tick();
            c_in_valid = '0;
        end
        #3;
        chk("c_held_ch2", c_out_data[2], 16'h00C2);
        chk("c_cleared_ch0", c_out_data[0], 0);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
